// File: rtl/clock_divide_verilog_pkg.sv
// Shared sizing helpers for the integer clock divider.
package clock_divide_verilog_pkg;

  // Counter width; a width of 1 is kept for illegal small divisors so elaboration reaches the range check.
  function automatic int cnt_width(input int divisor);
    return (divisor < 3) ? 1 : $clog2(divisor);
  endfunction

  function automatic int low_cycles(input int divisor);
    return divisor - (divisor / 2);
  endfunction

  function automatic int high_cycles(input int divisor);
    return divisor / 2;
  endfunction

endpackage

// File: rtl/clock_divide_verilog_counter.sv
// Modulo-N up counter with synchronous active-high reset; exposes current and next count.
module mod_n_counter
  import clock_divide_verilog_pkg::*;
#(
  parameter int N = 10,
  parameter int W = cnt_width(N)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_next,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST_C = W'(N - 1);
  localparam logic [W-1:0] ONE_C  = W'(1);
  localparam logic [W-1:0] ZERO_C = '0;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: wrap against N-1 so non-power-of-two moduli never overflow.
  always_comb begin
    cnt_d  = ZERO_C;
    o_wrap = (cnt_q == LAST_C);
    if (i_reset) begin
      cnt_d = ZERO_C;
    end else if (o_wrap) begin
      cnt_d = ZERO_C;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  // Count register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= ZERO_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_count      = cnt_q;
  assign o_count_next = cnt_d;

endmodule

// File: rtl/clock_divide_verilog.sv
// Integer clock divider: registered square wave of period DIVISOR plus a
// one-cycle strobe in the last input cycle of each output period.
module clock_divide_verilog
  import clock_divide_verilog_pkg::*;
#(
  parameter int DIVISOR = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_clock,
  output logic o_tick
);

  localparam int LOW_CYCLES  = low_cycles(DIVISOR);
  localparam int HIGH_CYCLES = high_cycles(DIVISOR);
  localparam int CW          = cnt_width(DIVISOR);

  localparam logic [CW-1:0] LOW_C = CW'(LOW_CYCLES);
  localparam logic [CW-1:0] PRE_C = CW'(DIVISOR - 2);

  if (DIVISOR < 2 || HIGH_CYCLES < 1) begin : g_divisor_range
    $error("clock_divide_verilog: DIVISOR must be at least 2");
  end

  logic [CW-1:0] cnt_s;
  logic [CW-1:0] cnt_next_s;
  logic          wrap_s;
  logic          o_clock_q;
  logic          o_clock_d;
  logic          o_tick_q;
  logic          o_tick_d;

  mod_n_counter #(
    .N (DIVISOR),
    .W (CW)
  ) u_counter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .o_count      (cnt_s),
    .o_count_next (cnt_next_s),
    .o_wrap       (wrap_s)
  );

  // Output decode from the next count; the next count reaches DIVISOR-1
  // exactly when the current count is DIVISOR-2, and the wrap edge always lands low.
  always_comb begin
    o_clock_d = 1'b0;
    o_tick_d  = 1'b0;
    if (i_reset) begin
      o_clock_d = 1'b0;
      o_tick_d  = 1'b0;
    end else begin
      o_clock_d = !wrap_s && (cnt_next_s >= LOW_C);
      o_tick_d  = (cnt_s == PRE_C);
    end
  end

  // Output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_clock_q <= 1'b0;
      o_tick_q  <= 1'b0;
    end else begin
      o_clock_q <= o_clock_d;
      o_tick_q  <= o_tick_d;
    end
  end

  assign o_clock = o_clock_q;
  assign o_tick  = o_tick_q;

endmodule

// File: tb/tb_clock_divide_verilog.sv
// Self-checking bench: three dividers (10, 5, 2) on one clock, directed
// scenarios followed by random reset pulses checked against a phase model.
module tb_clock_divide_verilog;

  logic clk;
  logic rst [3];
  logic oc  [3];
  logic ot  [3];

  int divs [3] = '{10, 5, 2};
  int pos  [3];
  int vectors = 0;
  int errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clock_divide_verilog #(.DIVISOR(10)) u_d10 (
    .i_clock(clk), .i_reset(rst[0]), .o_clock(oc[0]), .o_tick(ot[0]));
  clock_divide_verilog #(.DIVISOR(5)) u_d5 (
    .i_clock(clk), .i_reset(rst[1]), .o_clock(oc[1]), .o_tick(ot[1]));
  clock_divide_verilog #(.DIVISOR(2)) u_d2 (
    .i_clock(clk), .i_reset(rst[2]), .o_clock(oc[2]), .o_tick(ot[2]));

  // Phase within the output period, p = edges since the last reset edge.
  function automatic logic exp_clk(input int d, input int p);
    return ((p % d) >= (d - d / 2));
  endfunction

  function automatic logic exp_tick(input int d, input int p);
    return ((p % d) == (d - 1));
  endfunction

  // One rising edge, model update from the reset levels seen at that edge, then settle.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) pos[k] = 0;
      else        pos[k] = pos[k] + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (oc[k] !== 1'b0 || ot[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset: D=%0d got clk=%b tick=%b want clk=0 tick=0", divs[k], oc[k], ot[k]);
        end
      end
    end
  endtask

  task automatic test_d10_waveform();
    rst[0] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      logic ec, et;
      step();
      ec = ((i % 10) >= 5);
      et = ((i % 10) == 9);
      vectors++;
      if (oc[0] !== ec || ot[0] !== et) begin
        errors++;
        $display("FAIL d10_wave: edge %0d got clk=%b tick=%b want clk=%b tick=%b", i, oc[0], ot[0], ec, et);
      end
    end
  endtask

  task automatic test_midperiod_reset();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    repeat (7) step();
    vectors++;
    if (oc[0] !== 1'b1 || ot[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: got clk=%b tick=%b want clk=1 tick=0", oc[0], ot[0]);
    end
    rst[0] = 1'b1;
    step();
    vectors++;
    if (oc[0] !== 1'b0 || ot[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got clk=%b tick=%b want clk=0 tick=0", oc[0], ot[0]);
    end
    rst[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      logic ec, et;
      step();
      ec = (i >= 5) && (i <= 9);
      et = (i == 9);
      vectors++;
      if (oc[0] !== ec || ot[0] !== et) begin
        errors++;
        $display("FAIL mid_after: edge %0d got clk=%b tick=%b want clk=%b tick=%b", i, oc[0], ot[0], ec, et);
      end
    end
  endtask

  task automatic test_d5();
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      logic ec, et;
      step();
      ec = ((i % 5) >= 3);
      et = ((i % 5) == 4);
      vectors++;
      if (oc[1] !== ec || ot[1] !== et) begin
        errors++;
        $display("FAIL d5_wave: edge %0d got clk=%b tick=%b want clk=%b tick=%b", i, oc[1], ot[1], ec, et);
      end
    end
  endtask

  task automatic test_d2();
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      logic ec;
      step();
      ec = (i % 2 == 1);
      vectors++;
      if (oc[2] !== ec || ot[2] !== ec) begin
        errors++;
        $display("FAIL d2_wave: edge %0d got clk=%b tick=%b want clk=%b tick=%b", i, oc[2], ot[2], ec, ec);
      end
    end
  endtask

  task automatic test_long_reset();
    int rise [3];
    for (int k = 0; k < 3; k++) begin
      rst[k]  = 1'b1;
      rise[k] = 0;
    end
    for (int c = 0; c < 20; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (oc[k] !== 1'b0 || ot[k] !== 1'b0) begin
          errors++;
          $display("FAIL long_reset: D=%0d cycle %0d got clk=%b tick=%b want 0 0", divs[k], c, oc[k], ot[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        if (rise[k] == 0 && oc[k] === 1'b1) rise[k] = e;
      end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rise[k] != divs[k] - divs[k] / 2) begin
        errors++;
        $display("FAIL first_rise: D=%0d got edge %0d want edge %0d", divs[k], rise[k], divs[k] - divs[k] / 2);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) rst[k] = ($urandom_range(0, 15) == 0);
      step();
      for (int k = 0; k < 3; k++) begin
        logic ec, et;
        ec = exp_clk(divs[k], pos[k]);
        et = exp_tick(divs[k], pos[k]);
        vectors++;
        if (oc[k] !== ec || ot[k] !== et) begin
          errors++;
          $display("FAIL random: D=%0d cycle %0d got clk=%b tick=%b want clk=%b tick=%b", divs[k], c, oc[k], ot[k], ec, et);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      pos[k] = 0;
    end
    test_reset();
    test_d10_waveform();
    test_midperiod_reset();
    test_d5();
    test_d2();
    test_long_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
